// File: rtl/mem_port_arbiter.sv
// Arbitrates one fetch port and one load/store port onto a single memory bus.
// Data requests win, except after STARVE_MAX back-to-back data grants made while a fetch was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_mem_req,
  input  logic [3:0]        i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_mem_gnt,
  output logic              o_mem_rvalid,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_bus_req,
  output logic [3:0]        o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            r_state, w_nxt;
  logic              r_owner_if;
  logic              r_kill;
  logic [3:0]        r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [SW-1:0]     r_starve;
  logic              w_pick_if;
  logic              w_if_gnt;
  logic              w_mem_gnt;

  // Grants are combinational, so they are gated with rst_n to stay low during reset.
  always_comb begin
    w_nxt     = r_state;
    w_pick_if = i_if_req && (!i_mem_req || (r_starve == SW'(STARVE_MAX)));
    w_if_gnt  = 1'b0;
    w_mem_gnt = 1'b0;
    case (r_state)
      IDLE: begin
        w_if_gnt  = rst_n && w_pick_if;
        w_mem_gnt = rst_n && i_mem_req && !w_pick_if;
        if (i_if_req || i_mem_req) w_nxt = BUSY;
      end
      BUSY:    if (i_bus_ack) w_nxt = RESP;
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner_if <= 1'b0;
      r_kill     <= 1'b0;
      r_we       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_starve   <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        IDLE: begin
          if (w_if_gnt) begin
            r_owner_if <= 1'b1;
            r_we       <= '0;
            r_addr     <= i_if_addr;
            r_wdata    <= '0;
            r_kill     <= i_if_flush;
            r_starve   <= '0;
          end else if (w_mem_gnt) begin
            r_owner_if <= 1'b0;
            r_we       <= i_mem_we;
            r_addr     <= i_mem_addr;
            r_wdata    <= i_mem_wdata;
            r_kill     <= 1'b0;
            if (!i_if_req)                         r_starve <= '0;
            else if (r_starve != SW'(STARVE_MAX)) r_starve <= r_starve + SW'(1);
          end
        end
        BUSY: begin
          if (r_owner_if && i_if_flush) r_kill <= 1'b1;
          // Stores complete with zero data rather than whatever the bus returns.
          if (i_bus_ack) r_rdata <= (|r_we) ? '0 : i_bus_rdata;
        end
        RESP:    r_kill <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_if_gnt     = w_if_gnt;
  assign o_mem_gnt    = w_mem_gnt;
  assign o_bus_req    = (r_state == BUSY);
  assign o_bus_we     = o_bus_req ? r_we    : '0;
  assign o_bus_addr   = o_bus_req ? r_addr  : '0;
  assign o_bus_wdata  = o_bus_req ? r_wdata : '0;
  assign o_if_rvalid  = (r_state == RESP) && r_owner_if && !r_kill;
  assign o_mem_rvalid = (r_state == RESP) && !r_owner_if;
  assign o_if_rdata   = o_if_rvalid  ? r_rdata : '0;
  assign o_mem_rdata  = o_mem_rvalid ? r_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_if_req, i_if_flush, i_mem_req, i_bus_ack;
  logic [31:0] i_if_addr, i_mem_addr, i_mem_wdata, i_bus_rdata;
  logic [3:0]  i_mem_we;
  logic        o_if_gnt, o_if_rvalid, o_mem_gnt, o_mem_rvalid, o_bus_req;
  logic [31:0] o_if_rdata, o_mem_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .o_mem_gnt(o_mem_gnt), .o_mem_rvalid(o_mem_rvalid),
    .o_mem_rdata(o_mem_rdata), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        fl;
    logic        mr;
    logic [3:0]  we;
    logic [31:0] ma;
    logic [31:0] wd;
    logic        ak;
    logic [31:0] rd;
    logic [136:0] exp;
  } vec_t;

  // {if_gnt, mem_gnt, bus_req, bus_we, bus_addr, bus_wdata, if_rvalid, if_rdata, mem_rvalid, mem_rdata}
  function automatic logic [136:0] E(bit ig, bit mg, bit br, logic [3:0] bwe, logic [31:0] ba,
                                     logic [31:0] bwd, bit iv, logic [31:0] ird, bit mv,
                                     logic [31:0] mrd);
    return {ig, mg, br, bwe, ba, bwd, iv, ird, mv, mrd};
  endfunction

  function automatic vec_t V(bit ir, logic [31:0] ia, bit fl, bit mr, logic [3:0] we,
                             logic [31:0] ma, logic [31:0] wd, bit ak, logic [31:0] rd,
                             logic [136:0] e);
    vec_t v;
    v.ir = ir; v.ia = ia; v.fl = fl; v.mr = mr; v.we = we;
    v.ma = ma; v.wd = wd; v.ak = ak; v.rd = rd; v.exp = e;
    return v;
  endfunction

  function automatic logic [136:0] outs();
    return {o_if_gnt, o_mem_gnt, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata,
            o_if_rvalid, o_if_rdata, o_mem_rvalid, o_mem_rdata};
  endfunction

  task automatic chk(input string nm, input logic [136:0] act, input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_if_req = v.ir; i_if_addr = v.ia; i_if_flush = v.fl;
    i_mem_req = v.mr; i_mem_we = v.we; i_mem_addr = v.ma; i_mem_wdata = v.wd;
    i_bus_ack = v.ak; i_bus_rdata = v.rd;
  endtask

  vec_t vt[24];
  logic [136:0] Z;

  initial begin
    Z = E(0,0,0,0,0,0,0,0,0,0);
    // single load, ack 3 cycles after bus_req
    vt[0]  = V(0,0,0,1,0,'h100,0,0,0,          E(0,1,0,0,0,0,0,0,0,0));
    vt[1]  = V(0,0,0,0,0,0,0,0,0,              E(0,0,1,0,'h100,0,0,0,0,0));
    vt[2]  = V(0,0,0,0,0,0,0,0,0,              E(0,0,1,0,'h100,0,0,0,0,0));
    vt[3]  = V(0,0,0,0,0,0,0,0,0,              E(0,0,1,0,'h100,0,0,0,0,0));
    vt[4]  = V(0,0,0,0,0,0,0,1,'hDEADBEEF,     E(0,0,1,0,'h100,0,0,0,0,0));
    vt[5]  = V(0,0,0,0,0,0,0,0,0,              E(0,0,0,0,0,0,0,0,1,'hDEADBEEF));
    // stray ack in IDLE
    vt[6]  = V(0,0,0,0,0,0,0,1,'h5A5A5A5A,     Z);
    // store
    vt[7]  = V(0,0,0,1,'hF,'h300,'h12345678,0,0, E(0,1,0,0,0,0,0,0,0,0));
    vt[8]  = V(0,0,0,0,0,0,0,1,'hAAAA5555,     E(0,0,1,'hF,'h300,'h12345678,0,0,0,0));
    vt[9]  = V(0,0,0,0,0,0,0,0,0,              E(0,0,0,0,0,0,0,0,1,0));
    // fetch flushed one cycle before ack, then a clean fetch
    vt[10] = V(1,'h40,0,0,0,0,0,0,0,           E(1,0,0,0,0,0,0,0,0,0));
    vt[11] = V(0,0,0,0,0,0,0,0,0,              E(0,0,1,0,'h40,0,0,0,0,0));
    vt[12] = V(0,0,1,0,0,0,0,0,0,              E(0,0,1,0,'h40,0,0,0,0,0));
    vt[13] = V(0,0,0,0,0,0,0,1,'h11111111,     E(0,0,1,0,'h40,0,0,0,0,0));
    vt[14] = V(0,0,0,0,0,0,0,0,0,              Z);
    vt[15] = V(1,'h80,0,0,0,0,0,0,0,           E(1,0,0,0,0,0,0,0,0,0));
    vt[16] = V(0,0,0,0,0,0,0,1,'h22222222,     E(0,0,1,0,'h80,0,0,0,0,0));
    vt[17] = V(0,0,0,0,0,0,0,0,0,              E(0,0,0,0,0,0,1,'h22222222,0,0));
    // flush in the grant cycle
    vt[18] = V(1,'h44,1,0,0,0,0,0,0,           E(1,0,0,0,0,0,0,0,0,0));
    vt[19] = V(0,0,0,0,0,0,0,1,'h33333333,     E(0,0,1,0,'h44,0,0,0,0,0));
    vt[20] = V(0,0,0,0,0,0,0,0,0,              Z);
    // flush has no effect on a data transaction
    vt[21] = V(0,0,1,1,0,'h104,0,0,0,          E(0,1,0,0,0,0,0,0,0,0));
    vt[22] = V(0,0,1,0,0,0,0,1,'h44444444,     E(0,0,1,0,'h104,0,0,0,0,0));
    vt[23] = V(0,0,0,0,0,0,0,0,0,              E(0,0,0,0,0,0,0,0,1,'h44444444));
  end

  initial begin
    logic [9:0] exp_f;
    int ngnt, bcnt;
    drive(V(1,'h40,0,1,0,'h100,0,1,'h1,0));
    rst_n = 1'b0;
    #3 chk("reset_outs", outs(), E(0,0,0,0,0,0,0,0,0,0));
    drive(V(0,0,0,0,0,0,0,0,0,0));
    @(negedge clk); #3 rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #2 chk($sformatf("vec%0d", i), outs(), vt[i].exp);
    end

    // starvation: both requests held, ack one cycle after bus_req rises
    exp_f = 10'b10000_10000;
    ngnt = 0; bcnt = 0;
    drive(V(1,'h500,0,1,0,'h600,0,0,0,0));
    for (int c = 0; c < 300 && ngnt < 10; c++) begin
      @(negedge clk);
      bcnt = o_bus_req ? bcnt + 1 : 0;
      i_bus_ack = (bcnt == 2);
      #2;
      if (o_if_gnt || o_mem_gnt) begin
        chk($sformatf("starve_gnt%0d", ngnt), {136'd0, o_if_gnt}, {136'd0, exp_f[ngnt]});
        ngnt++;
      end
    end
    if (ngnt < 10) chk("starve_timeout", 137'(ngnt), 137'd10);
    i_if_req = 1'b0; i_mem_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bcnt = o_bus_req ? bcnt + 1 : 0;
      i_bus_ack = (bcnt == 2);
    end
    @(negedge clk); i_bus_ack = 1'b0;
    #2 chk("starve_drain_idle", outs(), Z);

    // reset while BUSY, then a fresh load
    @(negedge clk);
    drive(V(0,0,0,1,0,'h180,0,0,0,0));
    #2 chk("rst_pre_gnt", outs(), E(0,1,0,0,0,0,0,0,0,0));
    @(negedge clk);
    i_mem_req = 1'b0;
    #2 chk("rst_busy", outs(), E(0,0,1,0,'h180,0,0,0,0,0));
    #1 rst_n = 1'b0; i_mem_req = 1'b1;
    #1 chk("rst_async", outs(), Z);
    i_mem_req = 1'b0;
    @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    #2 chk("rst_abandoned", outs(), Z);
    @(negedge clk);
    drive(V(0,0,0,1,0,'h200,0,0,0,0));
    #2 chk("post_rst_gnt", outs(), E(0,1,0,0,0,0,0,0,0,0));
    @(negedge clk);
    i_mem_req = 1'b0;
    #2 chk("post_rst_bus", outs(), E(0,0,1,0,'h200,0,0,0,0,0));
    @(negedge clk);
    i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFEF00D;
    #2 chk("post_rst_ack", outs(), E(0,0,1,0,'h200,0,0,0,0,0));
    @(negedge clk);
    i_bus_ack = 1'b0;
    #2 chk("post_rst_rvalid", outs(), E(0,0,0,0,0,0,0,0,1,'hCAFEF00D));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; STARVE_MAX, default 4, max consecutive data grants while a fetch waits.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch request; if_addr stable while if_req=1 and if_gnt=0.
REQ-005 if_addr  in  ADDR_W  fetch address.
REQ-006 if_flush  in  1  cancel any accepted, not yet returned fetch.
REQ-007 if_gnt  out  1  fetch request accepted (1-cycle pulse).
REQ-008 if_rvalid / if_rdata  out  1 / DATA_W  fetch response pulse and data.
REQ-009 mem_req, mem_we[3:0], mem_addr, mem_wdata  in  1,4,ADDR_W,DATA_W  load/store request; payload stable until mem_gnt; mem_we=0 is a load.
REQ-010 mem_gnt  out  1  data request accepted (1-cycle pulse).
REQ-011 mem_rvalid / mem_rdata  out  1 / DATA_W  data response pulse and data.
REQ-012 bus_req, bus_we[3:0], bus_addr, bus_wdata  out  1,4,ADDR_W,DATA_W  shared memory port request.
REQ-013 bus_ack / bus_rdata  in  1 / DATA_W  memory completion and read data, valid in the ack cycle.

Function
REQ-014 FSM states: IDLE, BUSY, RESP; exactly one transaction outstanding at a time.
REQ-015 IDLE: if any request, assert the winner's gnt combinationally this cycle, latch its payload and owner, go BUSY; else stay IDLE with both gnt=0.
REQ-016 Arbitration: data wins over fetch unless starve_cnt==STARVE_MAX, then fetch wins.
REQ-017 starve_cnt: +1 on data grant with if_req=1; cleared on fetch grant or on data grant with if_req=0; saturates at STARVE_MAX.
REQ-018 BUSY: bus_req=1 driving latched bus_we/bus_addr/bus_wdata (bus_we=0 for fetches); hold until bus_ack; on bus_ack capture bus_rdata, go RESP.
REQ-019 RESP: assert owner's rvalid for exactly one cycle with captured data; go IDLE; no grant in RESP.
REQ-020 Store (bus_we≠0) completion: mem_rvalid=1 with mem_rdata=0.
REQ-021 Latency: grant cycle T, bus_req from T+1, ack at cycle A≥T+1, rvalid at A+1; next grant earliest A+2.
REQ-022 bus_ack while not BUSY is ignored.
REQ-023 if_flush=1 in the grant cycle of a fetch, or any cycle up to and including its bus_ack, sets a kill flag; the bus transaction still completes but if_rvalid is suppressed; flag clears in RESP.
REQ-024 if_flush in the same cycle as a fetch grant in IDLE kills that fetch (grant still pulses).
REQ-025 if_flush never affects a data transaction.
REQ-026 Non-owner rvalid is 0 every cycle; rdata outputs are 0 when their rvalid is 0.

Reset
REQ-027 rst_n=0 immediately forces IDLE, starve_cnt=0, kill flag=0, and all outputs 0, including mid-transaction; in-flight transaction is abandoned with no rvalid.
REQ-028 After rst_n rises, first grant possible in the first clock edge's cycle with a request.

Verification
REQ-029 Single load: mem_req, mem_addr=0x100, we=0; ack 3 cycles after bus_req with rdata=0xDEADBEEF -> mem_gnt at T, bus_addr=0x100 from T+1, mem_rvalid=1, mem_rdata=0xDEADBEEF at ack+1.
REQ-030 Simultaneous if_req and mem_req held continuously, STARVE_MAX=4, ack 1 cycle after bus_req -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-031 Store we=0xF, wdata=0x12345678 -> bus_we=0xF, bus_wdata=0x12345678 while BUSY; mem_rvalid=1, mem_rdata=0 at ack+1.
REQ-032 Fetch granted at 0x40, if_flush pulsed 1 cycle before ack -> bus transaction completes, if_rvalid never asserts, next fetch at 0x80 returns normally.
REQ-033 rst_n dropped while BUSY (bus_req=1) -> bus_req, gnts, rvalids 0 asynchronously; after release, a fresh load at 0x200 completes normally.
REQ-034 bus_ack pulsed in IDLE with no requests -> no rvalid, state stays IDLE.
